// File: rtl/hf_demod_pkg.sv
// rtl/hf_demod_pkg.sv - shared constants and helpers for the HF subcarrier demodulator
package hf_demod_pkg;

  localparam int EDGE_DETECT_THRESHOLD_DEFAULT = 5;

  typedef enum logic [2:0] {
    SNIFFER       = 3'd0,
    TAGSIM_LISTEN = 3'd1,
    TAGSIM_MOD    = 3'd2,
    READER_LISTEN = 3'd3,
    READER_MOD    = 3'd4
  } iso14443a_mode_e;

  // Edge filter output width: 3*max sample fits, plus a sign bit.
  function automatic int filt_width(input int adc_width);
    return adc_width + 3;
  endfunction

endpackage

// File: rtl/hf_edge_filter.sv
// rtl/hf_edge_filter.sv - 5-tap Gaussian-derivative edge detector with 4-deep sample history
module hf_edge_filter
  import hf_demod_pkg::*;
#(
  parameter int ADC_WIDTH = 8
) (
  input  logic                              ck_1356meg,
  input  logic                              nreset,
  input  logic                              enable,
  input  logic [ADC_WIDTH-1:0]              adc_d,
  output logic [filt_width(ADC_WIDTH)-1:0]  f
);

  localparam int FW = filt_width(ADC_WIDTH);

  logic [ADC_WIDTH-1:0] x1, x2, x3, x4;
  logic [FW-1:0]        lag, lead;

  always_ff @(posedge ck_1356meg or negedge nreset) begin
    if (!nreset) begin
      x1 <= '0;
      x2 <= '0;
      x3 <= '0;
      x4 <= '0;
    end else if (!enable) begin
      x1 <= '0;
      x2 <= '0;
      x3 <= '0;
      x4 <= '0;
    end else begin
      x1 <= adc_d;
      x2 <= x1;
      x3 <= x2;
      x4 <= x3;
    end
  end

  // Both sums are zero-extended, so the two's-complement difference is exact.
  always_comb begin
    lag  = {2'b00, x4, 1'b0} + {3'b000, x3};
    lead = {2'b00, adc_d, 1'b0} + {3'b000, x1};
    f    = lag - lead;
  end

endmodule

// File: rtl/hf_subcarrier_demod.sv
// rtl/hf_subcarrier_demod.sv - subcarrier edge demodulator, word packer and SSP master driver
module hf_subcarrier_demod
  import hf_demod_pkg::*;
#(
  parameter int ADC_WIDTH      = 8,
  parameter int SC_DIV         = 16,
  parameter int BITS_PER_FRAME = 8,
  parameter int THRESH_WIDTH   = 8
) (
  input  logic                        ck_1356meg,
  input  logic                        nreset,
  input  logic                        enable,
  input  logic [ADC_WIDTH-1:0]        adc_d,
  input  logic [THRESH_WIDTH-1:0]     threshold,
  input  logic [$clog2(SC_DIV)-1:0]   reset_phase,
  output logic                        curbit,
  output logic [BITS_PER_FRAME-1:0]   byte_out,
  output logic                        byte_strobe,
  output logic                        ssp_clk,
  output logic                        ssp_frame,
  output logic                        ssp_din
);

  localparam int PW   = $clog2(SC_DIV);
  localparam int KW   = $clog2(BITS_PER_FRAME);
  localparam int CW   = PW + KW;
  localparam int FW   = filt_width(ADC_WIDTH);
  localparam int CMPW = ((THRESH_WIDTH >= FW) ? THRESH_WIDTH : FW) + 2;

  logic [CW-1:0]              cnt;
  logic [PW-1:0]              p;
  logic [KW-1:0]              k, k_d;
  logic [FW-1:0]              f_raw;
  logic signed [FW-1:0]       f, fall_max, rise_min;
  logic signed [CMPW-1:0]     fall_ext, rise_ext, thr;
  logic [BITS_PER_FRAME-1:0]  collect, hold;
  logic                       f_pos, decision;

  hf_edge_filter #(.ADC_WIDTH(ADC_WIDTH)) u_edge_filter (
    .ck_1356meg (ck_1356meg),
    .nreset     (nreset),
    .enable     (enable),
    .adc_d      (adc_d),
    .f          (f_raw)
  );

  assign p = cnt[PW-1:0];
  assign k = cnt[CW-1:PW];

  always_comb begin
    f        = f_raw;
    f_pos    = !f_raw[FW-1] && (f_raw != '0);
    fall_ext = {{(CMPW-FW){fall_max[FW-1]}}, fall_max};
    rise_ext = {{(CMPW-FW){rise_min[FW-1]}}, rise_min};
    thr      = {{(CMPW-THRESH_WIDTH){1'b0}}, threshold};
    decision = (fall_ext > thr) && (rise_ext < -thr);
  end

  // Slot index BITS_PER_FRAME-1-k is ~k since the frame length is a power of two.
  always_ff @(posedge ck_1356meg or negedge nreset) begin
    if (!nreset) begin
      cnt         <= '0;
      k_d         <= '0;
      fall_max    <= '0;
      rise_min    <= '0;
      collect     <= '0;
      hold        <= '0;
      curbit      <= 1'b0;
      byte_out    <= '0;
      byte_strobe <= 1'b0;
      ssp_clk     <= 1'b0;
      ssp_frame   <= 1'b0;
      ssp_din     <= 1'b0;
    end else if (!enable) begin
      cnt         <= '0;
      k_d         <= '0;
      fall_max    <= '0;
      rise_min    <= '0;
      collect     <= '0;
      hold        <= '0;
      curbit      <= 1'b0;
      byte_out    <= '0;
      byte_strobe <= 1'b0;
      ssp_clk     <= 1'b0;
      ssp_frame   <= 1'b0;
      ssp_din     <= 1'b0;
    end else begin
      cnt <= cnt + CW'(1);
      if (p == reset_phase) begin
        curbit      <= decision;
        collect[~k] <= decision;
        fall_max    <= '0;
        rise_min    <= '0;
      end else begin
        if (f_pos && (f > fall_max))
          fall_max <= f;
        if (!f_pos && (f < rise_min))
          rise_min <= f;
      end

      byte_strobe <= (cnt == '0);
      if (cnt == '0) begin
        hold     <= collect;
        byte_out <= collect;
      end

      // k_d delays the slot select so ssp_din changes at offset 2, after hold has reloaded.
      ssp_clk   <= (p >= PW'(SC_DIV/2));
      ssp_frame <= (k == '0);
      k_d       <= k;
      ssp_din   <= hold[~k_d];
    end
  end

endmodule
